run_completion_monitor: RTL
===========================

Name: run_completion_monitor

Overview:
Synthesizable run supervisor for the single-cycle RISC-V core. It watches the fetch PC until the program reaches a configurable end address, or until the PC self-loops (halt idiom "j ."). It then walks up to N_CHECKS register-file read channels and compares each against an expected value. It reports pass, fail, timeout and cycle count, so a bench, FPGA top or LED/UART reporter can consume a single verdict instead of probing hierarchy.

Parameters:
XLEN, 32, datapath/PC width
N_CHECKS, 4, number of register-check channels (>=1)
TIMEOUT_W, 16, width of cycle counter and timeout limit
STALL_DETECT, 1, 1 = treat PC unchanged for STALL_CYCLES consecutive samples as program end
STALL_CYCLES, 4, consecutive equal PC samples that define a halt (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  pulse; begins a run from IDLE or DONE
fin_addr  in  XLEN  program end address (e.g. 0x000000bc)
timeout_limit  in  TIMEOUT_W  max RUN cycles; 0 = no timeout
pc  in  XLEN  core fetch PC, sampled every cycle
chk_en  in  N_CHECKS  per-channel enable
chk_raddr  in  5*N_CHECKS  register index per channel, channel i at bits [5i+4:5i]
chk_exp  in  XLEN*N_CHECKS  expected value per channel, packed the same way
rf_addr  out  5  debug read address to register file
rf_data  in  XLEN  combinational read data for rf_addr
busy  out  1  high in RUN or CHECK
done  out  1  verdict valid, held until start or reset
pass  out  1  all enabled checks matched
timed_out  out  1  run ended by timeout
halted_by_stall  out  1  run ended by PC self-loop detection
fail_idx  out  max(1,$clog2(N_CHECKS))  first failing channel
fail_got  out  XLEN  rf_data observed on failing channel
cycles  out  TIMEOUT_W  RUN cycles elapsed, saturating at all-ones

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0, rf_addr=0, internal index/stall counters 0.
- States: IDLE, RUN, CHECK, DONE.
- IDLE or DONE, start=1: enter RUN next edge. Clear cycles, done, pass, timed_out, halted_by_stall, fail_idx, fail_got. start in RUN or CHECK is ignored.
- RUN, each cycle:
  - Increment cycles (saturating); the exit cycle is counted.
  - Priority 1: pc==fin_addr -> CHECK.
  - Priority 2: STALL_DETECT=1 and pc has equalled the previous sample for STALL_CYCLES consecutive samples -> CHECK, set halted_by_stall.
  - The first RUN cycle only loads prev_pc. The stall count restarts whenever pc changes.
  - Priority 3: timeout_limit!=0 and this is RUN cycle number timeout_limit -> DONE with timed_out=1, pass=0. No checks are run.
  - An end-address hit or stall halt on the timeout cycle wins; timed_out stays 0.
- CHECK:
  - Registered index i runs 0..N_CHECKS-1, one channel per cycle. rf_addr = chk_raddr[i] combinationally from i; rf_data is compared in the same cycle.
  - chk_en[i]=1 and rf_data!=chk_exp[i] -> DONE, pass=0, fail_idx=i, fail_got=rf_data. Remaining channels are skipped.
  - Disabled channels still consume one cycle, which keeps latency deterministic.
  - i==N_CHECKS-1 with no mismatch -> DONE, pass=1. This also applies when all channels are disabled.
- Latency: done rises k+1 cycles after the exit-RUN cycle, where k = index of the first failing channel, or N_CHECKS-1 if none fail.
- DONE: done=1, busy=0, all verdict outputs held stable. rf_addr=0 outside CHECK.
- Comparisons are full XLEN, unsigned equality; no X-masking.

Test Plan:
- fin_addr=0xbc, timeout_limit=1000, pc=0,4,8,... from first RUN cycle; ch0 x10 exp 0x00fff05f, ch1 x2 exp 0x00100000, chk_en=0011, rf matches -> hit on RUN cycle 48, cycles=48; done=1, pass=1, 4 cycles after hit.
- Same, rf x10=0x00fff05e -> done 1 cycle after hit, pass=0, fail_idx=0, fail_got=0x00fff05e; ch1 never addressed (rf_addr never 2).
- timeout_limit=100, pc increments, never hits 0xbc -> done, timed_out=1, pass=0, cycles=100, rf_addr stays 0.
- pc stuck at 0x40 from cycle 10, fin_addr=0xbc, STALL_CYCLES=4, all checks match -> halted_by_stall=1 after 4th equal sample, pass=1, timed_out=0.
- timeout_limit=48, pc reaches 0xbc on RUN cycle 48 -> end-address hit wins: timed_out=0, checks run, pass=1.
- reset pulse mid-CHECK -> all outputs 0 immediately (async), state IDLE. Start pulse during RUN -> ignored; cycles not cleared.

Source files
------------

// File: rtl/run_completion_monitor.sv
// ============================================================================
//  run_completion_monitor
//  Watches the core PC for program end or halt, then checks register values.
//  Rev 1.0
// ============================================================================
`default_nettype none

module run_completion_monitor #(
  parameter int XLEN         = 32,
  parameter int N_CHECKS     = 4,
  parameter int TIMEOUT_W    = 16,
  parameter int STALL_DETECT = 1,
  parameter int STALL_CYCLES = 4,
  localparam int FI_W        = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [XLEN-1:0]          fin_addr,
  input  logic [TIMEOUT_W-1:0]     timeout_limit,
  input  logic [XLEN-1:0]          pc,
  input  logic [N_CHECKS-1:0]      chk_en,
  input  logic [5*N_CHECKS-1:0]    chk_raddr,
  input  logic [XLEN*N_CHECKS-1:0] chk_exp,
  output logic [4:0]               rf_addr,
  input  logic [XLEN-1:0]          rf_data,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timed_out,
  output logic                     halted_by_stall,
  output logic [FI_W-1:0]          fail_idx,
  output logic [XLEN-1:0]          fail_got,
  output logic [TIMEOUT_W-1:0]     cycles
);

  localparam int             SC_W       = $clog2(STALL_CYCLES + 1);
  localparam logic [SC_W-1:0] STALL_LAST = SC_W'(STALL_CYCLES - 1);
  localparam logic [FI_W-1:0] LAST_IDX   = FI_W'(N_CHECKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [XLEN-1:0]      prev_pc, prev_pc_nxt;
  logic                 first_run, first_run_nxt;
  logic [SC_W-1:0]      stall_cnt, stall_nxt;
  logic [FI_W-1:0]      idx, idx_nxt;
  logic [TIMEOUT_W-1:0] cycles_nxt, cyc_inc;
  logic                 pass_nxt, timed_out_nxt, halted_nxt;
  logic [FI_W-1:0]      fail_idx_nxt;
  logic [XLEN-1:0]      fail_got_nxt;

  logic [4:0]      raddr_arr [N_CHECKS];
  logic [XLEN-1:0] exp_arr   [N_CHECKS];

  genvar gi;
  generate
    for (gi = 0; gi < N_CHECKS; gi++) begin : g_unpack
      assign raddr_arr[gi] = chk_raddr[5*gi +: 5];
      assign exp_arr[gi]   = chk_exp[XLEN*gi +: XLEN];
    end
  endgenerate

  logic            end_hit, pc_same, stall_hit, to_hit, cur_en, mismatch;
  logic [4:0]      cur_raddr;
  logic [XLEN-1:0] cur_exp;

  assign cur_raddr = raddr_arr[idx];
  assign cur_exp   = exp_arr[idx];
  assign cur_en    = chk_en[idx];
  assign mismatch  = cur_en && (rf_data != cur_exp);

  assign rf_addr = (state == S_CHECK) ? cur_raddr : 5'd0;
  assign busy    = (state == S_RUN) || (state == S_CHECK);
  assign done    = (state == S_DONE);

  assign cyc_inc   = (&cycles) ? cycles : cycles + 1'b1;
  assign end_hit   = (pc == fin_addr);
  // The first RUN cycle has no valid previous sample to compare against.
  assign pc_same   = !first_run && (pc == prev_pc);
  assign stall_hit = (STALL_DETECT != 0) && pc_same && (stall_cnt == STALL_LAST);
  assign to_hit    = (timeout_limit != '0) && (cyc_inc == timeout_limit);

  always_comb begin
    state_nxt     = state;
    prev_pc_nxt   = prev_pc;
    first_run_nxt = first_run;
    stall_nxt     = stall_cnt;
    idx_nxt       = idx;
    cycles_nxt    = cycles;
    pass_nxt      = pass;
    timed_out_nxt = timed_out;
    halted_nxt    = halted_by_stall;
    fail_idx_nxt  = fail_idx;
    fail_got_nxt  = fail_got;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt     = S_RUN;
          first_run_nxt = 1'b1;
          stall_nxt     = '0;
          idx_nxt       = '0;
          cycles_nxt    = '0;
          pass_nxt      = 1'b0;
          timed_out_nxt = 1'b0;
          halted_nxt    = 1'b0;
          fail_idx_nxt  = '0;
          fail_got_nxt  = '0;
        end
      end
      S_RUN: begin
        cycles_nxt    = cyc_inc;
        prev_pc_nxt   = pc;
        first_run_nxt = 1'b0;
        if (!pc_same)
          stall_nxt = '0;
        else if (stall_cnt != STALL_LAST)
          stall_nxt = stall_cnt + 1'b1;

        // End-address and stall exits take precedence over the timeout.
        if (end_hit) begin
          state_nxt = S_CHECK;
          idx_nxt   = '0;
        end else if (stall_hit) begin
          state_nxt  = S_CHECK;
          idx_nxt    = '0;
          halted_nxt = 1'b1;
        end else if (to_hit) begin
          state_nxt     = S_DONE;
          timed_out_nxt = 1'b1;
          pass_nxt      = 1'b0;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          state_nxt    = S_DONE;
          pass_nxt     = 1'b0;
          fail_idx_nxt = idx;
          fail_got_nxt = rf_data;
        end else if (idx == LAST_IDX) begin
          state_nxt = S_DONE;
          pass_nxt  = 1'b1;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      prev_pc         <= '0;
      first_run       <= 1'b0;
      stall_cnt       <= '0;
      idx             <= '0;
      cycles          <= '0;
      pass            <= 1'b0;
      timed_out       <= 1'b0;
      halted_by_stall <= 1'b0;
      fail_idx        <= '0;
      fail_got        <= '0;
    end else begin
      state           <= state_nxt;
      prev_pc         <= prev_pc_nxt;
      first_run       <= first_run_nxt;
      stall_cnt       <= stall_nxt;
      idx             <= idx_nxt;
      cycles          <= cycles_nxt;
      pass            <= pass_nxt;
      timed_out       <= timed_out_nxt;
      halted_by_stall <= halted_nxt;
      fail_idx        <= fail_idx_nxt;
      fail_got        <= fail_got_nxt;
    end
  end

endmodule

`default_nettype wire
